// File: rtl/ftdi_rx_framer_if.sv
// Byte-stream and frame-status bundle between the FTDI receive side and the framer.
// master = byte source / frame consumer, slave = the framer itself.
interface ftdi_rx_framer_if;
    logic [7:0] in_rx_data;
    logic       in_rx_rdy;
    logic [7:0] out_cmd;
    logic [7:0] out_len;
    logic [7:0] out_pl_data;
    logic       out_pl_valid;
    logic       out_frame_ok;
    logic       out_frame_err;
    logic [1:0] out_err_code;
    logic       out_busy;

    modport master (
        output in_rx_data, in_rx_rdy,
        input  out_cmd, out_len, out_pl_data, out_pl_valid,
        input  out_frame_ok, out_frame_err, out_err_code, out_busy
    );

    modport slave (
        input  in_rx_data, in_rx_rdy,
        output out_cmd, out_len, out_pl_data, out_pl_valid,
        output out_frame_ok, out_frame_err, out_err_code, out_busy
    );
endinterface

// File: rtl/ftdi_rx_framer.sv
// Length-delimited frame recovery: SYNC, CMD, LEN, LEN payload bytes, CSUM.
// Payload is streamed out as it arrives; every frame ends in one ok/err pulse.
// An inter-byte idle watchdog aborts frames that stall mid-way.
module ftdi_rx_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         TO_W           = 16
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    ftdi_rx_framer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        csum;
    logic [TO_W-1:0]   to_cnt;

    // Frame FSM, checksum/length bookkeeping, idle watchdog and all registered outputs
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            csum              <= '0;
            to_cnt            <= '0;
            bus.out_cmd       <= '0;
            bus.out_len       <= '0;
            bus.out_pl_data   <= '0;
            bus.out_pl_valid  <= 1'b0;
            bus.out_frame_ok  <= 1'b0;
            bus.out_frame_err <= 1'b0;
            bus.out_err_code  <= '0;
            bus.out_busy      <= 1'b0;
        end else begin
            // pulses default low; each lasts exactly one cycle
            bus.out_pl_valid  <= 1'b0;
            bus.out_frame_ok  <= 1'b0;
            bus.out_frame_err <= 1'b0;

            if (bus.in_rx_rdy) begin
                // an arriving byte always beats a watchdog expiry in the same cycle
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.in_rx_data == SYNC_BYTE) begin
                            state        <= CMD;
                            bus.out_busy <= 1'b1;
                        end
                    end
                    CMD: begin
                        bus.out_cmd <= bus.in_rx_data;
                        csum        <= bus.in_rx_data;
                        state       <= LEN;
                    end
                    LEN: begin
                        bus.out_len <= bus.in_rx_data;
                        csum        <= csum + bus.in_rx_data;
                        if (bus.in_rx_data > MAX_LEN_B) begin
                            bus.out_frame_err <= 1'b1;
                            bus.out_err_code  <= ERR_LEN;
                            bus.out_busy      <= 1'b0;
                            state             <= IDLE;
                        end else if (bus.in_rx_data == 8'd0) begin
                            state <= CSUM;
                        end else begin
                            cnt   <= bus.in_rx_data;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        // SYNC_BYTE values here are plain data; no resync
                        bus.out_pl_data  <= bus.in_rx_data;
                        bus.out_pl_valid <= 1'b1;
                        csum             <= csum + bus.in_rx_data;
                        cnt              <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (bus.in_rx_data == csum) begin
                            bus.out_frame_ok <= 1'b1;
                        end else begin
                            bus.out_frame_err <= 1'b1;
                            bus.out_err_code  <= ERR_CSUM;
                        end
                        bus.out_busy <= 1'b0;
                        state        <= IDLE;
                    end
                    default: begin
                        bus.out_busy <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_LAST) begin
                    bus.out_frame_err <= 1'b1;
                    bus.out_err_code  <= ERR_TIMEOUT;
                    bus.out_busy      <= 1'b0;
                    state             <= IDLE;
                    to_cnt            <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule
